// File: rtl/car_sim_pkg.sv
// Shared definitions for the car command responder.
// Holds the heading encoding, the valid command header, the bit positions of
// every field in the command and detector frames, the relative-direction codes
// understood by grid_probe, the controller state type and the default grid size.
package car_sim_pkg;

  localparam int GRID_W_DEF = 8;
  // Coordinate width; the 3-bit position ports limit the grid to 8x8.
  localparam int CW = 3;

  localparam logic [1:0] HDR_OK = 2'b10;

  localparam logic [1:0] HDG_N = 2'd0;
  localparam logic [1:0] HDG_E = 2'd1;
  localparam logic [1:0] HDG_S = 2'd2;
  localparam logic [1:0] HDG_W = 2'd3;

  // Command frame {hdr[1:0], destroy, place, right, left, back, fwd}
  localparam int FB_FWD     = 0;
  localparam int FB_BACK    = 1;
  localparam int FB_LEFT    = 2;
  localparam int FB_RIGHT   = 3;
  localparam int FB_PLACE   = 4;
  localparam int FB_DESTROY = 5;
  localparam int FB_HDR_LO  = 6;
  localparam int FB_HDR_HI  = 7;

  // Detector frame {4'b0000, back, right, left, front}
  localparam int DB_FRONT = 0;
  localparam int DB_LEFT  = 1;
  localparam int DB_RIGHT = 2;
  localparam int DB_BACK  = 3;

  // Relative directions are clockwise quarter turns added to the heading.
  localparam logic [1:0] REL_FRONT = 2'd0;
  localparam logic [1:0] REL_RIGHT = 2'd1;
  localparam logic [1:0] REL_BACK  = 2'd2;
  localparam logic [1:0] REL_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_UPDATE,
    ST_RESPOND
  } state_e;

endpackage

// File: rtl/grid_probe.sv
// Combinational neighbour lookup.
// Given the car cell, its heading and a relative direction, returns the
// adjacent cell in that direction and flags whether it lies outside the grid.
// Ports:
//   pos_x_i, pos_y_i : current cell
//   heading_i        : absolute heading (N=0, E=1, S=2, W=3; N is +y)
//   rel_i            : relative direction (front/right/back/left)
//   nb_x_o, nb_y_o   : neighbour cell (meaningless when out_o is set)
//   out_o            : neighbour is outside the grid
module grid_probe
  import car_sim_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF
) (
  input  logic [CW-1:0] pos_x_i,
  input  logic [CW-1:0] pos_y_i,
  input  logic [1:0]    heading_i,
  input  logic [1:0]    rel_i,
  output logic [CW-1:0] nb_x_o,
  output logic [CW-1:0] nb_y_o,
  output logic          out_o
);

  localparam logic [CW-1:0] MAX_C = CW'(GRID_W - 1);

  logic [1:0] dir;

  always_comb begin
    // Two-bit add wraps naturally, giving the absolute direction mod 4.
    dir    = heading_i + rel_i;
    nb_x_o = pos_x_i;
    nb_y_o = pos_y_i;
    out_o  = 1'b0;
    case (dir)
      HDG_N: begin
        out_o  = (pos_y_i == MAX_C);
        nb_y_o = pos_y_i + 1'b1;
      end
      HDG_E: begin
        out_o  = (pos_x_i == MAX_C);
        nb_x_o = pos_x_i + 1'b1;
      end
      HDG_S: begin
        out_o  = (pos_y_i == '0);
        nb_y_o = pos_y_i - 1'b1;
      end
      HDG_W: begin
        out_o  = (pos_x_i == '0);
        nb_x_o = pos_x_i - 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/car_cmd_responder.sv
// Car command responder.
// Accepts one command frame at a time, updates a car on a GRID_W x GRID_W grid
// with a barrier map, and answers every well-formed command with a detector
// frame describing the four neighbouring cells. Malformed frames are counted
// and dropped without a response.
// Ports:
//   sys_clk, rst          : clock, asynchronous active-low reset
//   rx_data/valid/ready   : command frame input handshake
//   tx_data/valid/ready   : detector frame output handshake
//   pos_x, pos_y, heading : current car state
//   err_cnt               : saturating count of frames with a bad header
module car_cmd_responder
  import car_sim_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic [1:0]    heading,
  output logic [7:0]    err_cnt
);

  localparam int NCELL = GRID_W * GRID_W;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;

  state_e               state_q, state_d;
  logic [7:0]           frame_q, frame_d;
  logic [CW-1:0]        pos_x_q, pos_x_d;
  logic [CW-1:0]        pos_y_q, pos_y_d;
  logic [1:0]           hdg_q, hdg_d;
  logic [NCELL-1:0]     map_q, map_d;
  logic [7:0]           err_q, err_d;

  logic [CW-1:0]        f_x, f_y, r_x, r_y, b_x, b_y, l_x, l_y;
  logic                 f_out, r_out, b_out, l_out;
  logic [3:0]           det;

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return IW'(int'(y) * GRID_W + int'(x));
  endfunction

  function automatic logic cell_blocked(input logic [NCELL-1:0] map, input logic out,
                                        input logic [CW-1:0] x, input logic [CW-1:0] y);
    return out || map[cell_idx(x, y)];
  endfunction

  // All four probes look from the registered car state: before the update
  // while in UPDATE, after it while in RESPOND.
  grid_probe #(.GRID_W(GRID_W)) u_probe_front (
    .pos_x_i(pos_x_q), .pos_y_i(pos_y_q), .heading_i(hdg_q), .rel_i(REL_FRONT),
    .nb_x_o(f_x), .nb_y_o(f_y), .out_o(f_out)
  );
  grid_probe #(.GRID_W(GRID_W)) u_probe_right (
    .pos_x_i(pos_x_q), .pos_y_i(pos_y_q), .heading_i(hdg_q), .rel_i(REL_RIGHT),
    .nb_x_o(r_x), .nb_y_o(r_y), .out_o(r_out)
  );
  grid_probe #(.GRID_W(GRID_W)) u_probe_back (
    .pos_x_i(pos_x_q), .pos_y_i(pos_y_q), .heading_i(hdg_q), .rel_i(REL_BACK),
    .nb_x_o(b_x), .nb_y_o(b_y), .out_o(b_out)
  );
  grid_probe #(.GRID_W(GRID_W)) u_probe_left (
    .pos_x_i(pos_x_q), .pos_y_i(pos_y_q), .heading_i(hdg_q), .rel_i(REL_LEFT),
    .nb_x_o(l_x), .nb_y_o(l_y), .out_o(l_out)
  );

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      hdg_q   <= HDG_N;
      map_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      hdg_q   <= hdg_d;
      map_q   <= map_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    hdg_d   = hdg_q;
    map_d   = map_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          frame_d = rx_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (frame_q[FB_HDR_HI:FB_HDR_LO] != HDR_OK) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // Barrier op first, so a move into a freshly placed barrier is blocked.
        if ((frame_q[FB_PLACE] ^ frame_q[FB_DESTROY]) && !f_out)
          map_d[cell_idx(f_x, f_y)] = frame_q[FB_PLACE];
        if (frame_q[FB_FWD] ^ frame_q[FB_BACK]) begin
          if (frame_q[FB_FWD]) begin
            if (!cell_blocked(map_d, f_out, f_x, f_y)) begin
              pos_x_d = f_x;
              pos_y_d = f_y;
            end
          end else if (!cell_blocked(map_d, b_out, b_x, b_y)) begin
            pos_x_d = b_x;
            pos_y_d = b_y;
          end
        end
        if (frame_q[FB_LEFT] ^ frame_q[FB_RIGHT])
          hdg_d = frame_q[FB_RIGHT] ? hdg_q + 2'd1 : hdg_q - 2'd1;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    det           = '0;
    det[DB_FRONT] = cell_blocked(map_q, f_out, f_x, f_y);
    det[DB_LEFT]  = cell_blocked(map_q, l_out, l_x, l_y);
    det[DB_RIGHT] = cell_blocked(map_q, r_out, r_x, r_y);
    det[DB_BACK]  = cell_blocked(map_q, b_out, b_x, b_y);
  end

  // Gating with rst keeps rx_ready low for the whole time reset is held.
  assign rx_ready = (state_q == ST_IDLE) && rst;
  assign tx_valid = (state_q == ST_RESPOND);
  // The detector word only depends on registered state, so it holds steady
  // for as long as the consumer stalls.
  assign tx_data  = tx_valid ? {4'b0000, det} : 8'h00;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign heading  = hdg_q;
  assign err_cnt  = err_q;

endmodule

// File: doc/car_cmd_responder.md
CAR_CMD_RESPONDER -- requirements
Module: car_cmd_responder

Interface
REQ-001 GRID_W, default 8, grid cells per side (x, y each 0..GRID_W-1).
REQ-002 sys_clk  in  1  system clock (100 MHz).
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rx_data  in  8  command frame {2'b10, destroy, place, right, left, back, fwd}.
REQ-005 rx_valid  in  1  rx_data valid this cycle.
REQ-006 rx_ready  out  1  frame accepted when rx_valid & rx_ready.
REQ-007 tx_data  out  8  detector frame {4'b0000, back, right, left, front}.
REQ-008 tx_valid  out  1  tx_data valid; held until tx_ready.
REQ-009 tx_ready  in  1  consumer accepts tx_data when tx_valid & tx_ready.
REQ-010 pos_x, pos_y  out  3 each  current car cell.
REQ-011 heading  out  2  N=0, E=1, S=2, W=3; N is +y, E is +x.
REQ-012 err_cnt  out  8  count of frames dropped for bad header, saturating at 255.

Function
REQ-013 FSM states IDLE, DECODE, UPDATE, RESPOND; rx_ready=1 only in IDLE.
REQ-014 IDLE: on accept, latch rx_data and go to DECODE.
REQ-015 DECODE: if bits[7:6]!=2'b10, increment err_cnt (saturating), go to IDLE, emit no response; else go to UPDATE.
REQ-016 UPDATE applies, in order, against pre-update position/heading: barrier op, move, turn.
REQ-017 Barrier op targets the cell ahead: place sets it, destroy clears it; place&destroy, or an out-of-grid target, is a no-op.
REQ-018 Move: fwd steps one cell along heading, back one cell opposite; fwd&back is a no-op; blocked if target is outside the grid or holds a barrier (checked after the barrier op).
REQ-019 Turn: left rotates heading -1 mod 4, right +1 mod 4; left&right is a no-op.
REQ-020 RESPOND: tx_valid=1, tx_data computed from the post-update position/heading; a detector bit is 1 if its neighbour cell (front/left/right/back relative to heading) is outside the grid or holds a barrier.
REQ-021 tx_valid rises on the 3rd cycle after the accept cycle; tx_data is stable while tx_valid & ~tx_ready.
REQ-022 On tx_valid & tx_ready: return to IDLE; tx_valid=0 next cycle; next frame is accepted no earlier than the cycle after that.
REQ-023 Frames offered while rx_ready=0 are not accepted (the upstream holds them).
REQ-024 The barrier map is a GRID_W*GRID_W bit register; the car cell can never hold a barrier because placement targets only the cell ahead.

Reset
REQ-025 On rst=0 (any state, including mid-RESPOND): state IDLE, pos (0,0), heading N, barrier map cleared, err_cnt 0, tx_valid 0, tx_data 0, latched frame 0.
REQ-026 rx_ready is 0 while rst=0 and 1 in the first cycle after release.

Structure
REQ-027 Shared package car_sim_pkg holds heading encoding, header constant 2'b10, frame bit indices, detector bit indices, and the default GRID_W.
REQ-028 One sub-module, grid_probe: combinational; given pos, heading and a relative direction, returns the neighbour cell and an out-of-grid flag; instantiated for the barrier/move target and for the four detector bits.

Verification
REQ-029 Reset, send 8'h81 -> pos (0,1), heading N, tx_data 8'h02, tx_valid on the 3rd cycle after accept.
REQ-030 Reset, send 8'h41 -> no tx_valid, err_cnt 1, pos/heading unchanged; 256 bad frames -> err_cnt 255.
REQ-031 Reset, send 8'h90 -> tx_data 8'h0B; then 8'h81 -> pos stays (0,0), tx_data 8'h0B; then 8'hA0 -> tx_data 8'h0A.
REQ-032 Reset, send 8'h88 -> heading E, tx_data 8'h0C; send 8'h8D -> heading E unchanged, pos (1,0).
REQ-033 tx_ready held 0 for 5 cycles in RESPOND -> tx_valid/tx_data stable and rx_ready 0 throughout; a frame offered during the hold is accepted only after the handshake.
REQ-034 rst pulsed low during RESPOND after a move to (0,1) -> tx_valid 0, pos (0,0), heading N, map cleared.
